nbr_info_tx_streamer: RTL and testbench
=======================================

# nbr_info_tx_streamer

Reads neighbor-info words from the neighbor-info SRAM banks and serializes them onto one-bit-per-bank links framed by SOS/EOS strobes. It is the transmit end of the serial link that the neighbor-info controller's receivers deserialize into SRAM, and is used to move a bank image between chips or blocks. All banks stream in parallel from the same address sequence, and each bank has its own data line.

## Interface
- BW_MEM, 16, word width per bank, in bits (≥2)
- NUM_BANKS, 2, number of SRAM banks and serial data lines
- ADDR_W, 9, SRAM address width
- CNT_W, 9, width of word_count (max 256 words per transfer)
- clk  input  1  clock, all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  transfer request, single-cycle pulse
- base_addr  input  ADDR_W  first SRAM address, sampled when start is accepted
- word_count  input  CNT_W  number of words per bank, sampled when start is accepted
- bank_en  input  NUM_BANKS  per-bank enable, sampled when start is accepted
- sram_q  input  NUM_BANKS×BW_MEM  SRAM read data, 1-cycle read latency
- sram_if  output  NUM_BANKS×sram_if_t  per-bank {A, CEN (active-low), WEN (active-low), Data}
- sos  output  1  start-of-stream strobe
- eos  output  1  end-of-stream strobe
- tx_data  output  NUM_BANKS  serial data, MSB first
- busy  output  1  high from the cycle after start is accepted until the cycle after done
- done  output  1  single-cycle completion pulse

## Operation
- States: IDLE, SOS, SHIFT, EOS.
- IDLE: start is accepted only in IDLE; start in any other state is ignored. If word_count==0, assert done at T+1, stay in IDLE, and perform no SRAM access and no sos/eos. Otherwise latch base_addr, word_count and bank_en, then go to SOS.
- SOS (T+1): issue a read of word 0 to every enabled bank (CEN=0, WEN=1, A=base_addr).
- SHIFT: drive word k MSB first, one bit per cycle. The bit counter runs 0..P-1, where P=BW_MEM, or BW_MEM+1 with parity. While the bit at index P-2 is on the line and k<word_count-1, issue a read of A=base_addr+k+1. Load the shift register from sram_q on the last bit cycle. After the last bit of the last word, go to EOS.
- EOS: eos=1 and done=1 for one cycle, then IDLE.
- Address arithmetic is modulo 2^ADDR_W; base_addr+k wraps silently.
- Disabled banks: CEN=1 for the whole transfer, tx_data=0.
- Outside a read cycle: CEN=1, WEN=1, A=0, Data=0. WEN is never driven low, because this block only reads.

## Timing
- Reset values: state=IDLE; sos=0; eos=0; tx_data=0; busy=0; done=0; every bank CEN=1, WEN=1, A=0; all counters 0.
- Start accepted at cycle T:
  - read of word 0 is issued at T+1;
  - sos=1 at T+2, with tx_data=0;
  - word k occupies cycles S_k = T+3+k·P through S_k+P-1;
  - eos=1 and done=1 at S_(N-1)+P;
  - busy=1 from T+1 through S_(N-1)+P.
- Words are sent back-to-back with no gap cycles between them.
- sos, eos and tx_data are registered outputs. sram_if is combinational from the state.
- Asserting reset mid-transfer aborts immediately: all outputs take their reset values and no eos is sent.

## Configuration
- NBR_TX_PARITY_EN defined: after each word's LSB, send one even-parity bit (the XOR of the word), giving P=BW_MEM+1.
- NBR_TX_PARITY_EN undefined: P=BW_MEM and no parity bit is sent.

## Structure
- Shared package: sram_if_t (A, CEN, WEN, Data), and the BW_MEM, NUM_BANKS and ADDR_W defaults.
- Sub-module: nbr_info_tx_shifter, instantiated once per bank. It holds the load/shift register and optional parity, and drives tx_data[i].
- The top level holds the FSM, bit and word counters, and address generation.

## Test plan
- Reset, then start with base=0, count=1, bank_en=2'b11, SRAM word 0=0xA5C3:
  - reads at T+1;
  - sos at T+2;
  - tx_data bits 1010010111000011 on both lines over T+3..T+18;
  - eos and done at T+19;
  - busy low at T+20.
- count=3, base=0x1FE: read addresses 0x1FE, 0x1FF, 0x000 (wrap), 48 contiguous data cycles with no gaps.
- bank_en=2'b01: bank 1 has CEN=1 throughout and tx_data[1]=0; bank 0 streams normally.
- start pulsed again during SHIFT is ignored (no new sos, counters undisturbed). start with count=0 gives done at T+1 with no sos, no eos and no SRAM read.
- Reset asserted mid-word on word 1 of 4: all outputs return to reset values with no eos. A new start afterwards completes normally.
- With NBR_TX_PARITY_EN and word 0x0007: 17 bit cycles with parity bit=1, and eos at T+3+17.

Source files
------------

// File: rtl/nbr_info_tx_streamer_pkg.sv
// Shared types and defaults for the neighbor-info serial transmitter.
// Build option: NBR_TX_PARITY_EN appends one even-parity bit to every word.
package nbr_info_tx_streamer_pkg;

  localparam int unsigned BW_MEM    = 16;
  localparam int unsigned NUM_BANKS = 2;
  localparam int unsigned ADDR_W    = 9;

`ifdef NBR_TX_PARITY_EN
  localparam int unsigned PAR_BITS = 1;
`else
  localparam int unsigned PAR_BITS = 0;
`endif

  typedef struct packed {
    logic [ADDR_W-1:0] A;
    logic              CEN;
    logic              WEN;
    logic [BW_MEM-1:0] Data;
  } sram_if_t;

  typedef enum logic [1:0] {StIdle, StSos, StShift, StEos} state_e;

endpackage

// File: rtl/nbr_info_tx_shifter.sv
// Per-bank load/shift register driving one serial line, MSB first.
// Build option: NBR_TX_PARITY_EN appends the even-parity bit after the LSB.
module nbr_info_tx_shifter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [Width-1:0] word_i,
  output logic             tx_o
);
  import nbr_info_tx_streamer_pkg::*;

  localparam int unsigned P = Width + PAR_BITS;

  logic [P-1:0] sh_q, sh_d, load_val;

`ifdef NBR_TX_PARITY_EN
  assign load_val = en_i ? {word_i, ^word_i} : '0;
`else
  assign load_val = en_i ? word_i : '0;
`endif

  // Zeros shift in behind the word, so the line idles low once a word drains.
  always_comb begin
    sh_d = load_i ? load_val : {sh_q[P-2:0], 1'b0};
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) sh_q <= '0;
    else         sh_q <= sh_d;
  end

  assign tx_o = sh_q[P-1];

endmodule

// File: rtl/nbr_info_tx_streamer.sv
// Streams SRAM bank images onto one-bit-per-bank serial links framed by sos/eos.
// Build option: NBR_TX_PARITY_EN adds a parity bit per word (handled in the shifter).
module nbr_info_tx_streamer #(
  parameter int unsigned BW_MEM    = nbr_info_tx_streamer_pkg::BW_MEM,
  parameter int unsigned NUM_BANKS = nbr_info_tx_streamer_pkg::NUM_BANKS,
  parameter int unsigned ADDR_W    = nbr_info_tx_streamer_pkg::ADDR_W,
  parameter int unsigned CNT_W     = 9
) (
  input  logic                                               clk,
  input  logic                                               reset,
  input  logic                                               start,
  input  logic [ADDR_W-1:0]                                  base_addr,
  input  logic [CNT_W-1:0]                                   word_count,
  input  logic [NUM_BANKS-1:0]                               bank_en,
  input  logic [NUM_BANKS-1:0][BW_MEM-1:0]                   sram_q,
  output nbr_info_tx_streamer_pkg::sram_if_t [NUM_BANKS-1:0] sram_if,
  output logic                                               sos,
  output logic                                               eos,
  output logic [NUM_BANKS-1:0]                               tx_data,
  output logic                                               busy,
  output logic                                               done
);
  import nbr_info_tx_streamer_pkg::*;

  localparam int unsigned P    = BW_MEM + PAR_BITS;
  localparam int unsigned BitW = $clog2(P);
  localparam logic [BitW-1:0] BitLast = BitW'(P - 1);
  localparam logic [BitW-1:0] BitRead = BitW'(P - 2);

  state_e               state_q, state_d;
  logic [BitW-1:0]      bit_q, bit_d;
  logic [CNT_W-1:0]     ld_q, ld_d, cnt_q, cnt_d;
  logic [ADDR_W-1:0]    base_q, base_d;
  logic [NUM_BANKS-1:0] en_q, en_d;
  logic                 sos_q, sos_d, eos_q, eos_d, done_q, done_d;
  logic                 accept, zero_req, last_bit, more, load, rd;
  logic [ADDR_W-1:0]    rd_addr;

  assign accept   = (state_q == StIdle) && start;
  assign zero_req = (word_count == '0);
  assign last_bit = (state_q == StShift) && (bit_q == BitLast);
  // ld_q counts words already loaded into the shifters.
  assign more     = (ld_q != cnt_q);
  assign load     = last_bit && more;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept && !zero_req) state_d = StSos;
      StSos:   state_d = StShift;
      StShift: if (last_bit && !more) state_d = StEos;
      StEos:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy    = (state_q != StIdle);
    rd      = (state_q == StSos) ||
              ((state_q == StShift) && (bit_q == BitRead) && more);
    rd_addr = base_q + ADDR_W'(ld_q);
    for (int i = 0; i < int'(NUM_BANKS); i++) begin
      sram_if[i] = '{A: '0, CEN: 1'b1, WEN: 1'b1, Data: '0};
      if (rd && en_q[i]) begin
        sram_if[i].A   = rd_addr;
        sram_if[i].CEN = 1'b0;
      end
    end
  end

  always_comb begin
    bit_d  = bit_q;
    ld_d   = ld_q;
    cnt_d  = cnt_q;
    base_d = base_q;
    en_d   = en_q;
    if (accept && !zero_req) begin
      cnt_d  = word_count;
      base_d = base_addr;
      en_d   = bank_en;
    end
    unique case (state_q)
      // Entering SHIFT on the last-bit count makes word 0 load like any later word.
      StSos: begin
        bit_d = BitLast;
        ld_d  = '0;
      end
      StShift: begin
        if (last_bit) begin
          bit_d = '0;
          if (more) ld_d = ld_q + CNT_W'(1);
        end else begin
          bit_d = bit_q + BitW'(1);
        end
      end
      StEos: begin
        bit_d = '0;
        ld_d  = '0;
      end
      default: ;
    endcase
    sos_d  = (state_q == StSos);
    eos_d  = (state_d == StEos);
    done_d = eos_d || (accept && zero_req);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_q  <= '0;
      ld_q   <= '0;
      cnt_q  <= '0;
      base_q <= '0;
      en_q   <= '0;
      sos_q  <= 1'b0;
      eos_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      bit_q  <= bit_d;
      ld_q   <= ld_d;
      cnt_q  <= cnt_d;
      base_q <= base_d;
      en_q   <= en_d;
      sos_q  <= sos_d;
      eos_q  <= eos_d;
      done_q <= done_d;
    end
  end

  assign sos  = sos_q;
  assign eos  = eos_q;
  assign done = done_q;

  for (genvar g = 0; g < int'(NUM_BANKS); g++) begin : g_bank
    nbr_info_tx_shifter #(
      .Width(BW_MEM)
    ) u_shifter (
      .clk_i  (clk),
      .reset_i(reset),
      .load_i (load),
      .en_i   (en_q[g]),
      .word_i (sram_q[g]),
      .tx_o   (tx_data[g])
    );
  end

endmodule

// File: tb/tb_nbr_info_tx_streamer.sv
// Directed bench for nbr_info_tx_streamer with a 1-cycle-latency SRAM model.
module tb_nbr_info_tx_streamer;
  import nbr_info_tx_streamer_pkg::*;

`ifdef NBR_TX_PARITY_EN
  localparam int P = 17;
`else
  localparam int P = 16;
`endif

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 start;
  logic [8:0]           base_addr;
  logic [8:0]           word_count;
  logic [1:0]           bank_en;
  logic [1:0][15:0]     sram_q;
  sram_if_t [1:0]       sram_if;
  logic                 sos, eos, busy, done;
  logic [1:0]           tx_data;

  logic [15:0] mem [2][512];
  int n_tests = 0;
  int n_fail  = 0;

  nbr_info_tx_streamer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .word_count(word_count),
    .bank_en   (bank_en),
    .sram_q    (sram_q),
    .sram_if   (sram_if),
    .sos       (sos),
    .eos       (eos),
    .tx_data   (tx_data),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!sram_if[i].CEN) sram_q[i] <= mem[i][sram_if[i].A];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_word(input int b, input logic [8:0] a, input logic e);
    logic [15:0] w;
    w = e ? mem[b][a] : 16'h0;
`ifdef NBR_TX_PARITY_EN
    return {15'h0, w, ^w};
`else
    return {16'h0, w};
`endif
  endfunction

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_sos"}, sos, 0);
    check_eq({tag, "_eos"}, eos, 0);
    check_eq({tag, "_tx"}, tx_data, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_cen"}, {sram_if[1].CEN, sram_if[0].CEN}, 2'b11);
    check_eq({tag, "_wen"}, {sram_if[1].WEN, sram_if[0].WEN}, 2'b11);
    check_eq({tag, "_a0"}, sram_if[0].A, 0);
  endtask

  // Full transfer with per-cycle checks; restart_at pulses start at that cycle offset.
  task automatic xfer(input string name, input logic [8:0] base, input logic [8:0] cnt,
                      input logic [1:0] en, input int restart_at);
    int          last_c, k, b, n_sos, busy_bad, eos_early, wen_bad;
    int          n_rd [2];
    logic [31:0] got [2];
    logic        rd_exp;
    logic [8:0]  ra;
    last_c = 3 + int'(cnt) * P;
    n_sos = 0; busy_bad = 0; eos_early = 0; wen_bad = 0;
    n_rd[0] = 0; n_rd[1] = 0; got[0] = 0; got[1] = 0;
    base_addr = base; word_count = cnt; bank_en = en; start = 1'b1;
    step();
    start = 1'b0; base_addr = 9'h0AA; word_count = 9'd7; bank_en = ~en;
    for (int c = 1; c <= last_c; c++) begin
      rd_exp = 1'b0; ra = '0; k = 0; b = 0;
      if (c >= 3) begin
        k = (c - 3) / P;
        b = (c - 3) % P;
      end
      if (c == 1) begin
        rd_exp = 1'b1; ra = base;
      end else if (c >= 3 && b == P - 2 && k < int'(cnt) - 1) begin
        rd_exp = 1'b1; ra = base + 9'(k + 1);
      end
      for (int i = 0; i < 2; i++) begin
        if (!sram_if[i].CEN) n_rd[i]++;
        if (!sram_if[i].WEN) wen_bad++;
        if (rd_exp && en[i]) begin
          check_eq($sformatf("%s_rd%0d_c%0d_cen", name, i, c), sram_if[i].CEN, 0);
          check_eq($sformatf("%s_rd%0d_c%0d_addr", name, i, c), sram_if[i].A, ra);
        end
      end
      if (sos) n_sos++;
      if (busy !== 1'b1) busy_bad++;
      if (c < last_c && (eos || done)) eos_early++;
      if (c == 2) begin
        check_eq({name, "_sos"}, sos, 1);
        check_eq({name, "_sos_tx"}, tx_data, 0);
      end
      if (c >= 3 && c < last_c) begin
        for (int i = 0; i < 2; i++) begin
          got[i] = {got[i][30:0], tx_data[i]};
          if (b == P - 1) begin
            check_eq($sformatf("%s_w%0d_bank%0d", name, k, i), got[i],
                     exp_word(i, base + 9'(k), en[i]));
            got[i] = 0;
          end
        end
      end
      if (c == last_c) begin
        check_eq({name, "_eos"}, eos, 1);
        check_eq({name, "_done"}, done, 1);
        check_eq({name, "_eos_tx"}, tx_data, 0);
      end
      if (c == restart_at) begin
        start = 1'b1; base_addr = 9'h100; word_count = 9'd5; bank_en = 2'b11;
      end
      step();
      start = 1'b0;
    end
    check_eq({name, "_busy_end"}, busy, 0);
    check_eq({name, "_eos_end"}, eos, 0);
    check_eq({name, "_done_end"}, done, 0);
    check_eq({name, "_nsos"}, n_sos, 1);
    check_eq({name, "_busy_hold"}, busy_bad, 0);
    check_eq({name, "_eos_early"}, eos_early, 0);
    check_eq({name, "_wen_low"}, wen_bad, 0);
    check_eq({name, "_nrd0"}, n_rd[0], en[0] ? int'(cnt) : 0);
    check_eq({name, "_nrd1"}, n_rd[1], en[1] ? int'(cnt) : 0);
  endtask

  initial begin
    int n_eos;
    for (int a = 0; a < 512; a++) begin
      mem[0][a] = 16'(a * 37) ^ 16'h5A5A;
      mem[1][a] = 16'(a * 91) ^ 16'hC3E1;
    end
    mem[0][0] = 16'hA5C3;     mem[1][0] = 16'hA5C3;
    mem[0][9'h1FE] = 16'h1234; mem[1][9'h1FE] = 16'hFEDC;
    mem[0][9'h1FF] = 16'h8001; mem[1][9'h1FF] = 16'h7FFE;
    mem[0][9'h020] = 16'h0007; mem[1][9'h020] = 16'hF000;
    sram_q = '0;
    reset = 1'b1; start = 1'b0; base_addr = '0; word_count = '0; bank_en = '0;
    step();
    step();
    check_idle_outputs("reset");
    reset = 1'b0;
    step();

    xfer("single", 9'h000, 9'd1, 2'b11, 0);
    xfer("wrap", 9'h1FE, 9'd3, 2'b11, 10);
    xfer("bank0only", 9'h005, 9'd2, 2'b01, 0);
    xfer("parity", 9'h020, 9'd1, 2'b11, 0);

    // Zero-length request: done only, nothing else.
    base_addr = 9'h003; word_count = 9'd0; bank_en = 2'b11; start = 1'b1;
    step();
    start = 1'b0;
    check_eq("zero_done", done, 1);
    check_eq("zero_busy", busy, 0);
    check_eq("zero_sos", sos, 0);
    check_eq("zero_cen", {sram_if[1].CEN, sram_if[0].CEN}, 2'b11);
    step();
    check_idle_outputs("zero_after");

    // Abort on reset while word 1 of 4 is on the line.
    base_addr = 9'h040; word_count = 9'd4; bank_en = 2'b11; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c < 3 + P + 5; c++) step();
    check_eq("abort_busy_pre", busy, 1);
    reset = 1'b1;
    #1;
    check_idle_outputs("abort");
    step();
    step();
    reset = 1'b0;
    n_eos = 0;
    for (int c = 0; c < 2 * P; c++) begin
      if (eos || done || sos || busy) n_eos++;
      step();
    end
    check_eq("abort_quiet", n_eos, 0);
    xfer("after_abort", 9'h040, 9'd2, 2'b11, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
